mem_wb_stage: RTL and testbench
===============================

Name: mem_wb_stage

Overview:
- Memory/writeback pipeline register for the RV64 datapath.
- Registers the ALU result and the memory read data, and optionally aligns and extends load data.
- Directly feeds mux_2x1_64bit_S2: A = ALU result, B = load data, S = 2-bit writeback select.
- Also produces the register-file write controls and a 64-bit retired-instruction counter.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- RD_W, 5, destination register index width.

Ports:
- clk  in  1  rising-edge clock, the single clock of the block
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all registered state this cycle
- flush  in  1  insert a bubble this cycle
- in_valid  in  1  upstream instruction valid
- in_alu_result  in  64  ALU result from the EX/MEM stage
- in_mem_rdata  in  64  raw doubleword read from data memory
- in_addr_low  in  3  address bits [2:0] of the load
- in_funct3  in  3  load funct3
- in_mem_to_reg  in  1  1 = write back memory data, 0 = write back ALU result
- in_reg_write  in  1  instruction writes rd
- in_rd  in  5  destination register
- mux_a  out  64  to mux A input (registered ALU result)
- mux_b  out  64  to mux B input (registered, aligned load data)
- mux_s  out  2  to mux S input; 2'b00 selects A, 2'b11 selects B, never 01 or 10
- wb_valid  out  1  the stage holds a valid instruction
- wb_reg_write  out  1  register-file write enable
- wb_rd  out  5  register-file write index
- instret  out  64  count of instructions retired through this stage

Behaviour:
- All outputs are registered: one-cycle latency from inputs to outputs; no combinational input-to-output path.
- Update priority at each rising clk edge: reset > flush > stall > capture.
- reset: mux_a, mux_b, instret = 0; mux_s = 2'b00; wb_valid = 0; wb_reg_write = 0; wb_rd = 0. Reset asserted mid-stall or mid-flush still clears everything.
- flush: wb_valid = 0, wb_reg_write = 0, mux_s = 2'b00.
  - mux_a, mux_b and wb_rd hold their previous values.
  - instret is not incremented.
  - Flush wins over a simultaneous stall.
- stall (without flush): every register holds, including instret.
- capture (no reset, flush or stall):
  - mux_a = in_alu_result.
  - mux_b = aligned(in_mem_rdata) (see Optional Feature).
  - mux_s = {2{in_mem_to_reg}}.
  - wb_rd = in_rd.
  - wb_valid = in_valid.
  - wb_reg_write = in_valid & in_reg_write & (in_rd != 0); writes to x0 are suppressed.
  - When in_valid = 0, data fields are still captured but wb_reg_write = 0.
- instret increments by 1 on every capture with in_valid = 1. It wraps from 2^64-1 to 0 with no flag.
- The block applies no backpressure; the stall source is upstream hazard logic.

Optional Feature:
- Macro: WB_LOAD_ALIGN_EN.
- Defined: mux_b = extended load value, selected by in_funct3.
  - 000 LB: sign-extend byte at bit offset in_addr_low*8.
  - 001 LH: sign-extend halfword at in_addr_low[2:1]*16.
  - 010 LW: sign-extend word at in_addr_low[2]*32.
  - 011 LD: raw 64 bits.
  - 100 LBU, 101 LHU, 110 LWU: zero-extended forms of LB, LH, LW.
  - 111: raw 64 bits.
  - Misaligned halfword/word: the low address bits below the access size are ignored (truncated), with no trap.
- Undefined: mux_b = in_mem_rdata registered unchanged; in_funct3 and in_addr_low are ignored.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset then capture: assert reset 2 cycles, check every output is 0. Then in_valid=1, in_alu_result=1, in_mem_to_reg=0, in_reg_write=1, in_rd=5 → next cycle mux_a=1, mux_s=00, wb_reg_write=1, wb_rd=5, instret=1.
- Memory select: in_mem_rdata=2, in_funct3=011, in_mem_to_reg=1 → mux_b=2, mux_s=11. Driving the real mux_2x1_64bit_S2 from these outputs, its X equals 2; with in_mem_to_reg=0, X equals mux_a.
- Stall and flush: capture alu=7, then stall=1 with alu=9 for 3 cycles → mux_a stays 7 and instret is unchanged. Then stall=1 and flush=1 together → wb_valid=0, wb_reg_write=0, mux_a still 7.
- x0 suppression and bubbles: in_rd=0 with in_reg_write=1 → wb_reg_write=0, instret still increments. in_valid=0 → wb_reg_write=0, instret unchanged.
- Alignment (WB_LOAD_ALIGN_EN), in_mem_rdata=64'h8877_6655_4433_2211:
  - LB, addr_low=7 → FFFF_FFFF_FFFF_FF88.
  - LBU, addr_low=7 → 0000_0000_0000_0088.
  - LH, addr_low=2 → 0000_0000_0000_4433.
  - LW, addr_low=4 → FFFF_FFFF_8877_6655.
  - LWU, addr_low=4 → 0000_0000_8877_6655.
  - Without the macro, every case returns the raw value.
- Wrap and mid-operation reset: force instret to 64'hFFFF_FFFF_FFFF_FFFF, capture one valid instruction → instret=0. Assert reset during stall=1 → all outputs 0 on the next edge.

Source files
------------

// File: rtl/mem_wb_stage.sv
// Memory/writeback pipeline register: registers ALU result and load data, builds
// register-file write controls and a retired-instruction counter. Optional macro WB_LOAD_ALIGN_EN.
module mem_wb_stage #(
  parameter int XLEN = 64,
  parameter int RD_W = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            flush,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_rdata,
  input  logic [2:0]      in_addr_low,
  input  logic [2:0]      in_funct3,
  input  logic            in_mem_to_reg,
  input  logic            in_reg_write,
  input  logic [RD_W-1:0] in_rd,
  output logic [XLEN-1:0] mux_a,
  output logic [XLEN-1:0] mux_b,
  output logic [1:0]      mux_s,
  output logic            wb_valid,
  output logic            wb_reg_write,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] instret
);

  logic [XLEN-1:0] mux_a_q, mux_a_d;
  logic [XLEN-1:0] mux_b_q, mux_b_d;
  logic [1:0]      mux_s_q, mux_s_d;
  logic            wb_valid_q, wb_valid_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic [RD_W-1:0] wb_rd_q, wb_rd_d;
  logic [XLEN-1:0] instret_q, instret_d;
  logic [XLEN-1:0] load_data;

`ifdef WB_LOAD_ALIGN_EN
  // Sub-access address bits are truncated, so misaligned halfword/word loads read the enclosing lane.
  function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] raw,
                                                 input logic [2:0]      addr_low,
                                                 input logic [2:0]      funct3);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = 8'(raw >> {addr_low, 3'b000});
    h = 16'(raw >> {addr_low[2:1], 4'b0000});
    w = 32'(raw >> {addr_low[2], 5'b00000});
    case (funct3)
      3'b000:  align_load = XLEN'(b);
      3'b001:  align_load = XLEN'(h);
      3'b010:  align_load = XLEN'(w);
      3'b100:  align_load = {{(XLEN-8){1'b0}}, b};
      3'b101:  align_load = {{(XLEN-16){1'b0}}, h};
      3'b110:  align_load = {{(XLEN-32){1'b0}}, w};
      default: align_load = raw;
    endcase
  endfunction

  assign load_data = align_load(in_mem_rdata, in_addr_low, in_funct3);
`else
  logic unused_align;
  assign unused_align = ^{in_addr_low, in_funct3};
  assign load_data    = in_mem_rdata;
`endif

  always_comb begin
    mux_a_d        = mux_a_q;
    mux_b_d        = mux_b_q;
    mux_s_d        = mux_s_q;
    wb_valid_d     = wb_valid_q;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    instret_d      = instret_q;
    if (flush) begin
      wb_valid_d     = 1'b0;
      wb_reg_write_d = 1'b0;
      mux_s_d        = 2'b00;
    end else if (!stall) begin
      mux_a_d        = in_alu_result;
      mux_b_d        = load_data;
      mux_s_d        = {2{in_mem_to_reg}};
      wb_rd_d        = in_rd;
      wb_valid_d     = in_valid;
      wb_reg_write_d = in_valid & in_reg_write & (in_rd != '0);
      if (in_valid) instret_d = instret_q + XLEN'(1);
    end
  end

  // MEM -> WB register boundary
  always_ff @(posedge clk) begin
    if (reset) begin
      mux_a_q        <= '0;
      mux_b_q        <= '0;
      mux_s_q        <= 2'b00;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= '0;
      instret_q      <= '0;
    end else begin
      mux_a_q        <= mux_a_d;
      mux_b_q        <= mux_b_d;
      mux_s_q        <= mux_s_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      instret_q      <= instret_d;
    end
  end

  assign mux_a        = mux_a_q;
  assign mux_b        = mux_b_q;
  assign mux_s        = mux_s_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign instret      = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed, table-driven bench for mem_wb_stage; expected load data follows WB_LOAD_ALIGN_EN.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [63:0] in_alu_result, in_mem_rdata;
  logic [2:0]  in_addr_low, in_funct3;
  logic        in_mem_to_reg, in_reg_write;
  logic [4:0]  in_rd;
  logic [63:0] mux_a, mux_b, instret;
  logic [1:0]  mux_s;
  logic        wb_valid, wb_reg_write;
  logic [4:0]  wb_rd;

  int n_checks = 0;
  int n_fail   = 0;

  mem_wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
    .in_alu_result(in_alu_result), .in_mem_rdata(in_mem_rdata), .in_addr_low(in_addr_low),
    .in_funct3(in_funct3), .in_mem_to_reg(in_mem_to_reg), .in_reg_write(in_reg_write),
    .in_rd(in_rd), .mux_a(mux_a), .mux_b(mux_b), .mux_s(mux_s), .wb_valid(wb_valid),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, flush, valid;
    logic [63:0] alu, rdata;
    logic [2:0]  addr, f3;
    logic        m2r, rw;
    logic [4:0]  rd;
    logic [63:0] e_a, e_b;
    logic [1:0]  e_s;
    logic        e_v, e_rw;
    logic [4:0]  e_rd;
    logic [63:0] e_ir;
  } vec_t;

  localparam logic [63:0] RAW = 64'h8877_6655_4433_2211;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mux_a"}, mux_a, 64'd0);
    check({tag, "_mux_b"}, mux_b, 64'd0);
    check({tag, "_mux_s"}, 64'(mux_s), 64'd0);
    check({tag, "_wb_valid"}, 64'(wb_valid), 64'd0);
    check({tag, "_wb_reg_write"}, 64'(wb_reg_write), 64'd0);
    check({tag, "_wb_rd"}, 64'(wb_rd), 64'd0);
    check({tag, "_instret"}, instret, 64'd0);
  endtask

  task automatic drive(input logic st, input logic fl, input logic v, input logic [63:0] alu,
                       input logic [63:0] rdata, input logic [2:0] addr, input logic [2:0] f3,
                       input logic m2r, input logic rw, input logic [4:0] rd);
    stall = st; flush = fl; in_valid = v; in_alu_result = alu; in_mem_rdata = rdata;
    in_addr_low = addr; in_funct3 = f3; in_mem_to_reg = m2r; in_reg_write = rw; in_rd = rd;
  endtask

  vec_t vecs[20];

  function automatic logic [63:0] ld(input logic [63:0] aligned);
`ifdef WB_LOAD_ALIGN_EN
    return aligned;
`else
    return (aligned == aligned) ? RAW : RAW;
`endif
  endfunction

  initial begin
    logic [63:0] mux_x;
    // stall flush valid alu rdata addr f3 m2r rw rd | a b s v rw rd ir
    vecs[0]  = '{0,0,1, 64'd1,  64'd0, 3'd0,3'd3, 0,1,5'd5, 64'd1,  64'd0, 2'b00,1,1,5'd5, 64'd1};
    vecs[1]  = '{0,0,1, 64'd3,  64'd2, 3'd0,3'd3, 1,1,5'd6, 64'd3,  64'd2, 2'b11,1,1,5'd6, 64'd2};
    vecs[2]  = '{0,0,1, 64'd7,  64'd0, 3'd0,3'd3, 0,1,5'd7, 64'd7,  64'd0, 2'b00,1,1,5'd7, 64'd3};
    vecs[3]  = '{1,0,1, 64'd9,  64'd5, 3'd0,3'd3, 1,1,5'd9, 64'd7,  64'd0, 2'b00,1,1,5'd7, 64'd3};
    vecs[4]  = '{1,0,1, 64'd9,  64'd5, 3'd0,3'd3, 1,1,5'd9, 64'd7,  64'd0, 2'b00,1,1,5'd7, 64'd3};
    vecs[5]  = '{1,0,1, 64'd9,  64'd5, 3'd0,3'd3, 1,1,5'd9, 64'd7,  64'd0, 2'b00,1,1,5'd7, 64'd3};
    vecs[6]  = '{1,1,1, 64'd9,  64'd5, 3'd0,3'd3, 1,1,5'd9, 64'd7,  64'd0, 2'b00,0,0,5'd7, 64'd3};
    vecs[7]  = '{0,0,1, 64'd10, 64'd0, 3'd0,3'd3, 0,1,5'd0, 64'd10, 64'd0, 2'b00,1,0,5'd0, 64'd4};
    vecs[8]  = '{0,0,0, 64'd11, 64'd4, 3'd0,3'd3, 1,1,5'd3, 64'd11, 64'd4, 2'b11,0,0,5'd3, 64'd4};
    vecs[9]  = '{0,1,1, 64'd12, 64'd6, 3'd0,3'd3, 1,1,5'd4, 64'd11, 64'd4, 2'b00,0,0,5'd3, 64'd4};
    vecs[10] = '{0,0,1, 64'd13, 64'd0, 3'd0,3'd3, 0,0,5'd8, 64'd13, 64'd0, 2'b00,1,0,5'd8, 64'd5};
    vecs[11] = '{0,0,1, 64'd0, RAW, 3'd7,3'b000, 1,1,5'd1, 64'd0, ld(64'hFFFF_FFFF_FFFF_FF88), 2'b11,1,1,5'd1, 64'd6};
    vecs[12] = '{0,0,1, 64'd0, RAW, 3'd7,3'b100, 1,1,5'd1, 64'd0, ld(64'h0000_0000_0000_0088), 2'b11,1,1,5'd1, 64'd7};
    vecs[13] = '{0,0,1, 64'd0, RAW, 3'd2,3'b001, 1,1,5'd1, 64'd0, ld(64'h0000_0000_0000_4433), 2'b11,1,1,5'd1, 64'd8};
    vecs[14] = '{0,0,1, 64'd0, RAW, 3'd4,3'b010, 1,1,5'd1, 64'd0, ld(64'hFFFF_FFFF_8877_6655), 2'b11,1,1,5'd1, 64'd9};
    vecs[15] = '{0,0,1, 64'd0, RAW, 3'd4,3'b110, 1,1,5'd1, 64'd0, ld(64'h0000_0000_8877_6655), 2'b11,1,1,5'd1, 64'd10};
    vecs[16] = '{0,0,1, 64'd0, RAW, 3'd5,3'b011, 1,1,5'd1, 64'd0, RAW, 2'b11,1,1,5'd1, 64'd11};
    vecs[17] = '{0,0,1, 64'd0, RAW, 3'd7,3'b001, 1,1,5'd1, 64'd0, ld(64'hFFFF_FFFF_FFFF_8877), 2'b11,1,1,5'd1, 64'd12};
    vecs[18] = '{0,0,1, 64'd0, RAW, 3'd3,3'b010, 1,1,5'd1, 64'd0, ld(64'h0000_0000_4433_2211), 2'b11,1,1,5'd1, 64'd13};
    vecs[19] = '{0,0,1, 64'd0, RAW, 3'd6,3'b101, 1,1,5'd1, 64'd0, ld(64'h0000_0000_0000_8877), 2'b11,1,1,5'd1, 64'd14};

    reset = 1'b1;
    drive(0, 0, 0, 64'd0, 64'd0, 3'd0, 3'd0, 0, 0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    foreach (vecs[i]) begin
      drive(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].alu, vecs[i].rdata,
            vecs[i].addr, vecs[i].f3, vecs[i].m2r, vecs[i].rw, vecs[i].rd);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_mux_a", i), mux_a, vecs[i].e_a);
      check($sformatf("v%0d_mux_b", i), mux_b, vecs[i].e_b);
      check($sformatf("v%0d_mux_s", i), 64'(mux_s), 64'(vecs[i].e_s));
      check($sformatf("v%0d_wb_valid", i), 64'(wb_valid), 64'(vecs[i].e_v));
      check($sformatf("v%0d_wb_reg_write", i), 64'(wb_reg_write), 64'(vecs[i].e_rw));
      check($sformatf("v%0d_wb_rd", i), 64'(wb_rd), 64'(vecs[i].e_rd));
      check($sformatf("v%0d_instret", i), instret, vecs[i].e_ir);
      if (i == 1 || i == 2) begin
        mux_x = (mux_s == 2'b11) ? mux_b : mux_a;
        check($sformatf("v%0d_mux_x", i), mux_x, (i == 1) ? 64'd2 : 64'd7);
      end
    end

    // counter wrap from all-ones
    drive(1, 0, 0, 64'd0, 64'd0, 3'd0, 3'd3, 0, 0, 5'd0);
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    drive(0, 0, 1, 64'd55, 64'd0, 3'd0, 3'd3, 0, 1, 5'd2);
    @(posedge clk);
    #1;
    check("wrap_instret", instret, 64'd0);
    drive(0, 0, 1, 64'd56, 64'd0, 3'd0, 3'd3, 0, 1, 5'd2);
    @(posedge clk);
    #1;
    check("post_wrap_instret", instret, 64'd1);
    check("post_wrap_mux_a", mux_a, 64'd56);

    // reset during stall
    drive(1, 0, 1, 64'd77, 64'd1, 3'd0, 3'd3, 1, 1, 5'd9);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst_stall");
    reset = 1'b0;

    // reset during flush, after a fresh capture
    drive(0, 0, 1, 64'd88, 64'd3, 3'd0, 3'd3, 1, 1, 5'd4);
    @(posedge clk);
    #1;
    check("pre_rst_flush_instret", instret, 64'd1);
    drive(1, 1, 1, 64'd99, 64'd3, 3'd0, 3'd3, 1, 1, 5'd4);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("rst_flush");
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
